// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// UART_RX_PARITY_EN adds the PARITY state to the state enum.
package uart_pkg;
  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_rx_state_t;
endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer with a configurable reset value.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits, LSB first, mid-bit sampling, valid/ready output.
// Define UART_RX_PARITY_EN for a parity bit, parity_odd input and parity_err flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_enable,
  input  logic                      rxd,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_err,
  output logic                      overrun,
`ifdef UART_RX_PARITY_EN
  input  logic                      parity_odd,
  output logic                      parity_err,
`endif
  input  logic                      err_clr
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_cfg
    $error("uart_rx: CLKS_PER_BIT must be >= 4");
  end

  uart_rx_state_t       state, state_n;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 rxd_s, rxd_q;
  logic                 fall, tick_half, tick_bit;
  logic                 data_smp, deliver, frame_set;

  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  always_ff @(posedge clk) begin
    if (rst) rxd_q <= 1'b1;
    else     rxd_q <= rxd_s;
  end

  assign fall      = rxd_q & ~rxd_s;
  assign tick_half = (cnt == HALF_M1);
  assign tick_bit  = (cnt == LAST);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // next state; losing rx_enable mid-frame aborts without side effects
  always_comb begin
    state_n = state;
    if (state != IDLE && !rx_enable) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:   if (fall && rx_enable) state_n = START;
        START:  if (tick_half) state_n = rxd_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
        DATA:   if (tick_bit && bit_cnt == LAST_BIT) state_n = PARITY;
        PARITY: if (tick_bit) state_n = STOP;
`else
        DATA:   if (tick_bit && bit_cnt == LAST_BIT) state_n = STOP;
`endif
        STOP:   if (tick_bit) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_set;
`endif

  // output decode
  always_comb begin
    data_smp  = rx_enable && state == DATA && tick_bit;
    deliver   = rx_enable && state == STOP && tick_bit && rxd_s;
    frame_set = rx_enable && state == STOP && tick_bit && !rxd_s;
`ifdef UART_RX_PARITY_EN
    par_set   = rx_enable && state == PARITY && tick_bit &&
                (rxd_s != (^shreg ^ parity_odd));
`endif
  end

  // bit timer restarts on every state change so each phase is measured from its entry
  always_ff @(posedge clk) begin
    if (rst || state == IDLE || state_n != state) cnt <= '0;
    else if (tick_bit)                            cnt <= '0;
    else                                          cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      if (state == IDLE && state_n == START) bit_cnt <= '0;
      else if (data_smp)                     bit_cnt <= bit_cnt + 1'b1;
      if (data_smp) shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
    end
  end

  // delivery and sticky flags; a set on the same edge beats err_clr
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (deliver && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      frame_err <= frame_set | (frame_err & ~err_clr);
      overrun   <= (deliver && rx_valid && !rx_ready) | (overrun & ~err_clr);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= par_set | (parity_err & ~err_clr);
  end
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit: directed scenarios plus random frames.
// Define UART_RX_PARITY_EN to exercise the parity build.
module tb_uart_rx;
  localparam int CPB = 16;

  logic       clk, rst, rx_enable, rxd, rx_ready, err_clr;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_odd, parity_err;
`endif

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_enable  (rx_enable),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_odd (parity_odd),
    .parity_err (parity_err),
`endif
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: every transfer must match the oldest expected byte
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", rx_valid, 1);
        check("hold_data", rx_data, prev_data);
      end
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_byte: got %0h, want none (t=%0t)", rx_data, $time);
        end else begin
          check("rx_data", rx_data, exp_q.pop_front());
        end
      end
      prev_hold = rx_valid && !rx_ready;
      prev_data = rx_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    tick(CPB);
  endtask

  function automatic logic ref_par(input logic [7:0] b, input logic odd);
    return ^b ^ odd;
  endfunction

  // full frame; par_ok/stop_ok choose a correct or corrupted parity and stop bit
  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input logic par_ok);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_ok ? ref_par(b, parity_odd) : ~ref_par(b, parity_odd));
`else
    if (!par_ok) $display("note: parity ignored in 8N1 build");
`endif
    send_bit(stop_ok);
    rxd = 1'b1;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    logic       bad_stop, bad_par;
    rst = 1'b1; rx_enable = 1'b1; rxd = 1'b1; rx_ready = 1'b1; err_clr = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0;
`endif
    tick(3);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    tick(5);

    // clean byte
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b1);
    tick(8);
    check("a5_frame_err", frame_err, 0);
    check("a5_overrun", overrun, 0);

    // short glitch is a false start
    rxd = 1'b0; tick(4); rxd = 1'b1;
    tick(40);
    check("glitch_valid", rx_valid, 0);
    check("glitch_frame_err", frame_err, 0);

    // bad stop bit
    send_frame(8'h3C, 1'b0, 1'b1);
    tick(4);
    check("stop_low_frame_err", frame_err, 1);
    check("stop_low_valid", rx_valid, 0);
    pulse_clr();
    check("frame_err_cleared", frame_err, 0);
    tick(4);

    // overrun: second byte dropped, first held
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b1);
    tick(4);
    send_frame(8'h22, 1'b1, 1'b1);
    tick(4);
    check("ovr_valid", rx_valid, 1);
    check("ovr_data", rx_data, 8'h11);
    check("ovr_flag", overrun, 1);
    rx_ready = 1'b1;
    tick(2);
    check("ovr_drained", rx_valid, 0);
    pulse_clr();
    check("overrun_cleared", overrun, 0);
    tick(4);

    // rx_enable dropped mid bit 3 aborts the frame
    b = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(b[i]);
    rxd = b[3]; tick(CPB / 2);
    rx_enable = 1'b0; tick(CPB / 2);
    for (int i = 4; i < 8; i++) send_bit(b[i]);
    send_bit(1'b1);
    tick(4);
    rx_enable = 1'b1;
    tick(4);
    check("abort_valid", rx_valid, 0);
    check("abort_frame_err", frame_err, 0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, 1'b1);
    tick(8);

    // reset mid-frame: line stays high afterwards, so nothing may arrive
    b = 8'hF0;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(b[i]);
    rxd = b[5]; tick(CPB / 2);
    rst = 1'b1; tick(2); rst = 1'b0;
    tick(CPB / 2 + 2 * CPB + CPB);
    check("midrst_valid", rx_valid, 0);
    check("midrst_frame_err", frame_err, 0);

`ifdef UART_RX_PARITY_EN
    // even parity, wrong parity bit: flagged but delivered
    parity_odd = 1'b0;
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, 1'b0);
    tick(4);
    check("par_err_set", parity_err, 1);
    check("par_frame_err", frame_err, 0);
    pulse_clr();
    check("par_err_cleared", parity_err, 0);
    tick(4);
`endif

    // random frames
    for (int k = 0; k < 24; k++) begin
      b        = 8'($urandom);
      bad_stop = ($urandom_range(0, 9) == 0);
      bad_par  = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_odd = 1'($urandom);
      bad_par    = ($urandom_range(0, 4) == 0);
`endif
      if (!bad_stop) exp_q.push_back(b);
      send_frame(b, !bad_stop, !bad_par);
      tick(4);
      check("rand_frame_err", frame_err, bad_stop);
      check("rand_overrun", overrun, 0);
`ifdef UART_RX_PARITY_EN
      check("rand_parity_err", parity_err, bad_par);
`endif
      pulse_clr();
      tick($urandom_range(3, 20));
    end

    tick(20);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200); SHALL be >= 4.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; only 8 is supported.
REQ-003 Port clk, input, 1, sole clock; every flop SHALL be rising-edge clk.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port rx_enable, input, 1, receiver enable.
REQ-006 Port rxd, input, 1, asynchronous serial line; idles high.
REQ-007 Port rx_data, output, 8, received byte, LSB first on the wire.
REQ-008 Port rx_valid, output, 1, rx_data holds an unconsumed byte.
REQ-009 Port rx_ready, input, 1, downstream (AXI register block) accepts the byte.
REQ-010 Port frame_err, output, 1, sticky flag: stop bit sampled low.
REQ-011 Port overrun, output, 1, sticky flag: a byte completed while rx_valid was high.
REQ-012 Port err_clr, input, 1, one-cycle pulse that clears all sticky flags.

Function
REQ-013 rxd SHALL pass through a 2-flop synchronizer (reset value 1) before any use; all timing below counts from the synchronized signal.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP.
REQ-015 IDLE: on a synchronized falling edge with rx_enable=1, go to START and clear the bit counter.
REQ-016 START: at CLKS_PER_BIT/2 (integer divide) cycles, a low sample goes to DATA; a high sample is a false start and returns to IDLE with no flag set.
REQ-017 DATA: sample once every CLKS_PER_BIT cycles (mid-bit) and shift the sample into bit 7 of a shift register with a right shift; after 8 samples go to STOP, or to PARITY when the macro is defined.
REQ-018 STOP: sample once after CLKS_PER_BIT cycles; low sets frame_err and discards the byte; high delivers the byte. Either way, go to IDLE on the same cycle.
REQ-019 Delivery: with rx_valid=0, rx_data and rx_valid=1 SHALL update on the cycle after the stop sample.
REQ-020 Delivery with rx_valid=1 and rx_ready=0: set overrun, drop the new byte, keep the old byte.
REQ-021 Handshake: a transfer is rx_valid and rx_ready both high on a clock edge; rx_valid drops on the next cycle unless a new byte is delivered on that same edge, in which case rx_valid stays 1 with the new data and no overrun.
REQ-022 rx_data SHALL remain stable while rx_valid=1 and no transfer occurs.
REQ-023 rx_enable deasserted in any state other than IDLE: abort to IDLE on the next cycle; no byte, no flag; a pending rx_valid is unaffected.
REQ-024 err_clr coincident with a flag-set event: the set wins.
REQ-025 The bit-timing counter SHALL be clog2(CLKS_PER_BIT) bits wide and wrap to 0 at CLKS_PER_BIT-1.

Reset
REQ-026 rst SHALL force state IDLE, counters 0, shift register 0, rx_data 0x00, rx_valid 0, frame_err 0, overrun 0, parity_err 0, and synchronizer flops 1.
REQ-027 rst asserted mid-frame SHALL discard the partial byte; the receiver SHALL wait for a fresh falling edge after release.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: add input parity_odd (1 = odd, 0 = even parity), add sticky output parity_err, and enable the PARITY state (one sample, then STOP).
REQ-029 A parity mismatch sets parity_err but still delivers the byte; err_clr also clears parity_err.
REQ-030 Macro undefined: frame is 8N1; the PARITY state, parity_odd and parity_err SHALL NOT exist.

Structure
REQ-031 Package uart_pkg SHALL hold the state enum uart_rx_state_t, the constant UART_DATA_BITS=8, and the default CLKS_PER_BIT constant.
REQ-032 Sub-module uart_sync SHALL be a 2-flop synchronizer with a reset value parameter, instantiated once for rxd.

Verification (CLKS_PER_BIT=16)
REQ-033 Send 0xA5 as 8N1 with rx_ready=1 -> rx_valid pulses for one cycle with rx_data=0xA5, no flags set.
REQ-034 Low glitch of 4 cycles on rxd -> false start, no rx_valid, FSM returns to IDLE.
REQ-035 Send 0x3C with the stop bit held low -> frame_err=1, rx_valid stays 0; an err_clr pulse then clears frame_err.
REQ-036 Send 0x11 then 0x22 with rx_ready=0 -> rx_data=0x11, overrun=1; rx_ready=1 then takes 0x11.
REQ-037 Drop rx_enable during data bit 3, then raise it -> no output; the next byte 0x7E is received correctly.
REQ-038 With UART_RX_PARITY_EN and parity_odd=0, send 0x01 with parity bit 0 -> rx_data=0x01 delivered and parity_err=1.
